// File: rtl/lbm_collider_d2q9_param.sv
// D2Q9 BGK collision unit with a full equilibrium computation.
// Five register stages: input capture, moments, velocity, f_eq, relax/clamp.
//
// Handshake: a beat is accepted on an edge where in_valid && in_ready, and
// delivered on an edge where out_valid && out_ready. The pipeline advances as
// a whole (adv = !out_valid || out_ready); in_ready equals adv, so a
// full-but-stalled output freezes every stage, bubbles included.
module lbm_collider_d2q9_param #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 13,
    parameter int ACC_W = 2*WIDTH+4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     omega,
    input  logic                 solid,
    input  logic [9*WIDTH-1:0]   f_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9*WIDTH-1:0]   f_out,
    output logic                 sat
);
    // Moment width (sum of nine lanes never wraps) and velocity width (+-1.0).
    localparam int SW    = WIDTH + 4;
    localparam int UW    = FRAC + 2;
    localparam int ONE_I = 1 << FRAC;

    localparam logic signed [ACC_W-1:0] K_ONE     = ACC_W'(ONE_I);
    localparam logic signed [ACC_W-1:0] K_NEG_ONE = -K_ONE;
    localparam logic signed [ACC_W-1:0] K_C45     = ACC_W'((9 * ONE_I) / 2);
    localparam logic signed [ACC_W-1:0] K_C15     = ACC_W'((3 * ONE_I) / 2);
    localparam logic signed [ACC_W-1:0] K_MAX     = ACC_W'((1 << (WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] K_MIN     = ACC_W'(-(1 << (WIDTH-1)));

    // Lattice weights rounded to nearest: 4/9, 1/9, 1/36.
    localparam int W_REST = (8 * ONE_I + 9) / 18;
    localparam int W_AXIS = (2 * ONE_I + 9) / 18;
    localparam int W_DIAG = (2 * ONE_I + 36) / 72;

    // Lane order: 0 null, 1 n, 2 ne, 3 e, 4 se, 5 s, 6 sw, 7 w, 8 nw.
    function automatic int dir_x(input int i);
        case (i)
            2, 3, 4: return 1;
            6, 7, 8: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int dir_y(input int i);
        case (i)
            1, 2, 8: return 1;
            4, 5, 6: return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int opp(input int i);
        if (i == 0) return 0;
        return (i <= 4) ? i + 4 : i - 4;
    endfunction

    function automatic int weight(input int i);
        if (i == 0) return W_REST;
        return (i % 2 == 1) ? W_AXIS : W_DIAG;
    endfunction

    logic adv;

    logic                     v1, v2, v3, v4;
    logic [9*WIDTH-1:0]       s1_f, s2_f, s3_f, s4_f;
    logic [WIDTH-1:0]         s1_om, s2_om, s3_om, s4_om;
    logic                     s1_solid, s2_solid, s3_solid, s4_solid;
    logic signed [SW-1:0]     s2_rho, s2_jx, s2_jy, s3_rho;
    logic signed [UW-1:0]     s3_ux, s3_uy;
    logic [9*ACC_W-1:0]       s4_feq;

    logic signed [SW-1:0]     rho_c, jx_c, jy_c;
    logic signed [UW-1:0]     ux_c, uy_c;
    logic [9*ACC_W-1:0]       feq_c;
    logic [9*WIDTH-1:0]       fout_c;
    logic                     sat_c;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Moments: density and momentum summed over the captured lanes.
    always_comb begin : moments
        logic signed [SW-1:0] lane;
        rho_c = '0;
        jx_c  = '0;
        jy_c  = '0;
        lane  = '0;
        for (int i = 0; i < 9; i++) begin
            lane  = SW'($signed(s1_f[i*WIDTH +: WIDTH]));
            rho_c = rho_c + lane;
            if (dir_x(i) > 0)      jx_c = jx_c + lane;
            else if (dir_x(i) < 0) jx_c = jx_c - lane;
            if (dir_y(i) > 0)      jy_c = jy_c + lane;
            else if (dir_y(i) < 0) jy_c = jy_c - lane;
        end
    end

    // Velocity: u = j/rho in Q.FRAC, zero for non-positive density, clamped to +-1.0.
    always_comb begin : velocity
        logic signed [ACC_W-1:0] num_x, num_y, den, qx, qy;
        num_x = ACC_W'(s2_jx) <<< FRAC;
        num_y = ACC_W'(s2_jy) <<< FRAC;
        den   = ACC_W'(s2_rho);
        qx    = '0;
        qy    = '0;
        if (!s2_rho[SW-1] && (s2_rho != '0)) begin
            qx = num_x / den;
            qy = num_y / den;
        end
        if (qx > K_ONE)          qx = K_ONE;
        else if (qx < K_NEG_ONE) qx = K_NEG_ONE;
        if (qy > K_ONE)          qy = K_ONE;
        else if (qy < K_NEG_ONE) qy = K_NEG_ONE;
        ux_c = UW'(qx);
        uy_c = UW'(qy);
    end

    // Equilibrium: f_eq = w*rho*(1 + 3cu + 4.5cu^2 - 1.5usq), each product rescaled by FRAC.
    always_comb begin : equilibrium
        logic signed [ACC_W-1:0] ux, uy, rho, usq, cu, cu2, poly, wr;
        ux    = ACC_W'(s3_ux);
        uy    = ACC_W'(s3_uy);
        rho   = ACC_W'(s3_rho);
        usq   = ((ux * ux) >>> FRAC) + ((uy * uy) >>> FRAC);
        cu    = '0;
        cu2   = '0;
        poly  = '0;
        wr    = '0;
        feq_c = '0;
        for (int i = 0; i < 9; i++) begin
            cu = '0;
            if (dir_x(i) > 0)      cu = cu + ux;
            else if (dir_x(i) < 0) cu = cu - ux;
            if (dir_y(i) > 0)      cu = cu + uy;
            else if (dir_y(i) < 0) cu = cu - uy;
            cu2  = (cu * cu) >>> FRAC;
            poly = K_ONE + cu + (cu <<< 1) + ((K_C45 * cu2) >>> FRAC)
                   - ((K_C15 * usq) >>> FRAC);
            wr   = (ACC_W'(weight(i)) * rho) >>> FRAC;
            feq_c[i*ACC_W +: ACC_W] = (wr * poly) >>> FRAC;
        end
    end

    // Relaxation or bounce-back per lane, then saturate to the lane width.
    always_comb begin : relax
        logic signed [ACC_W-1:0] fl, fq, om, res;
        fl     = '0;
        fq     = '0;
        res    = '0;
        om     = ACC_W'($signed(s4_om));
        fout_c = '0;
        sat_c  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            fl = ACC_W'($signed(s4_f[i*WIDTH +: WIDTH]));
            fq = $signed(s4_feq[i*ACC_W +: ACC_W]);
            if (s4_solid) res = ACC_W'($signed(s4_f[opp(i)*WIDTH +: WIDTH]));
            else          res = fl + ((om * (fq - fl)) >>> FRAC);
            if (res > K_MAX) begin
                res   = K_MAX;
                sat_c = 1'b1;
            end else if (res < K_MIN) begin
                res   = K_MIN;
                sat_c = 1'b1;
            end
            fout_c[i*WIDTH +: WIDTH] = res[WIDTH-1:0];
        end
    end

    // Pipeline registers: everything advances together on adv, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            out_valid <= 1'b0;
            f_out     <= '0;
            sat       <= 1'b0;
            s1_f      <= '0;
            s2_f      <= '0;
            s3_f      <= '0;
            s4_f      <= '0;
            s1_om     <= '0;
            s2_om     <= '0;
            s3_om     <= '0;
            s4_om     <= '0;
            s1_solid  <= 1'b0;
            s2_solid  <= 1'b0;
            s3_solid  <= 1'b0;
            s4_solid  <= 1'b0;
            s2_rho    <= '0;
            s2_jx     <= '0;
            s2_jy     <= '0;
            s3_rho    <= '0;
            s3_ux     <= '0;
            s3_uy     <= '0;
            s4_feq    <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            s1_f      <= f_in;
            s1_om     <= omega;
            s1_solid  <= solid;

            v2        <= v1;
            s2_f      <= s1_f;
            s2_om     <= s1_om;
            s2_solid  <= s1_solid;
            s2_rho    <= rho_c;
            s2_jx     <= jx_c;
            s2_jy     <= jy_c;

            v3        <= v2;
            s3_f      <= s2_f;
            s3_om     <= s2_om;
            s3_solid  <= s2_solid;
            s3_rho    <= s2_rho;
            s3_ux     <= ux_c;
            s3_uy     <= uy_c;

            v4        <= v3;
            s4_f      <= s3_f;
            s4_om     <= s3_om;
            s4_solid  <= s3_solid;
            s4_feq    <= feq_c;

            out_valid <= v4;
            f_out     <= fout_c;
            sat       <= sat_c;
        end
    end

endmodule
